// File: rtl/er_proof_pkg.sv
// Shared types and defaults for the ER proof-of-execution tracker.
package er_proof_pkg;

  // Default width of pc and of the ER bounds.
  localparam int unsigned ADDR_W_DEFAULT = 16;
  // Default width of the completed-run counter.
  localparam int unsigned CNT_W_DEFAULT  = 8;

  // Tracker FSM; the encodings are visible on the run_state port.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2,
    StFail = 2'd3
  } run_state_t;

endpackage

// File: rtl/er_snapshot_hs.sv
// Snapshot handshake for the attestation engine: captures the live proof flag on a
// rising snap_req and holds it, frozen, until snap_req drops.
module er_snapshot_hs (
  input  logic clk,
  input  logic reset,
  input  logic snap_req,
  input  logic proof_valid,
  output logic snap_ack,
  output logic snap_proof
);

  logic snap_req_q;
  logic snap_ack_q, snap_ack_d;
  logic snap_proof_q, snap_proof_d;
  logic req_rise;

  // A capture needs a fresh rising edge, so a request held high never re-captures.
  assign req_rise = snap_req && !snap_req_q;

  // Next-state: release on a low request, capture on a new request, otherwise hold.
  always_comb begin
    snap_ack_d   = snap_ack_q;
    snap_proof_d = snap_proof_q;
    if (!snap_req) begin
      snap_ack_d   = 1'b0;
      snap_proof_d = 1'b0;
    end else if (!snap_ack_q && req_rise) begin
      snap_ack_d   = 1'b1;
      snap_proof_d = proof_valid;
    end
  end

  // Handshake registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_req_q   <= 1'b0;
      snap_ack_q   <= 1'b0;
      snap_proof_q <= 1'b0;
    end else begin
      snap_req_q   <= snap_req;
      snap_ack_q   <= snap_ack_d;
      snap_proof_q <= snap_proof_d;
    end
  end

  assign snap_ack   = snap_ack_q;
  assign snap_proof = snap_proof_q;

endmodule

// File: rtl/er_proof_tracker.sv
// Tracks one execution of the Executable Region from ER_min to ER_max and reports a
// registered proof-of-execution flag plus a sticky violation flag.
// Optional macro ER_PROOF_RUN_COUNT_EN adds a saturating completed-run counter.
module er_proof_tracker
  import er_proof_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              exec_in,
  input  logic              isr_active,
  input  logic [ADDR_W-1:0] ER_min,
  input  logic [ADDR_W-1:0] ER_max,
  input  logic              snap_req,
  output logic              snap_ack,
  output logic              snap_proof,
  output logic              proof_valid,
  output logic              violation,
  output logic [1:0]        run_state,
  output logic [CNT_W-1:0]  run_count
);

  run_state_t state_q, state_d;
  logic       violation_q, violation_d;
  logic       proof_valid_q;
  logic       cfg_ok, in_er, entry;

  assign cfg_ok = ER_min <= ER_max;
  assign in_er  = (pc >= ER_min) && (pc <= ER_max);
  assign entry  = exec_in && cfg_ok && (pc == ER_min);

  // Next-state and violation flag, first matching rule wins.
  always_comb begin
    state_d     = state_q;
    violation_d = violation_q;
    if ((state_q == StRun || state_q == StDone) && (!exec_in || !cfg_ok)) begin
      state_d     = StFail;
      violation_d = 1'b1;
    end else if (entry) begin
      // Also covers re-entry while already in RUN.
      state_d     = StRun;
      violation_d = 1'b0;
    end else if (state_q == StRun && pc == ER_max) begin
      state_d     = StDone;
    end else if (state_q == StRun && !in_er && !isr_active) begin
      state_d     = StFail;
      violation_d = 1'b1;
    end
  end

  // State and flag registers; proof_valid is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      violation_q   <= 1'b0;
      proof_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      violation_q   <= violation_d;
      proof_valid_q <= (state_d == StDone);
    end
  end

  assign run_state   = state_q;
  assign violation   = violation_q;
  assign proof_valid = proof_valid_q;

`ifdef ER_PROOF_RUN_COUNT_EN
  logic             run_done;
  logic [CNT_W-1:0] run_count_q, run_count_d;

  assign run_done = (state_q == StRun) && (state_d == StDone);

  // Saturating count of RUN->DONE transitions.
  always_comb begin
    run_count_d = run_count_q;
    if (run_done && (run_count_q != {CNT_W{1'b1}})) begin
      run_count_d = run_count_q + CNT_W'(1);
    end
  end

  // Counter register; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_count_q <= '0;
    end else begin
      run_count_q <= run_count_d;
    end
  end

  assign run_count = run_count_q;
`else
  assign run_count = '0;
`endif

  er_snapshot_hs u_snapshot_hs (
    .clk         (clk),
    .reset       (reset),
    .snap_req    (snap_req),
    .proof_valid (proof_valid_q),
    .snap_ack    (snap_ack),
    .snap_proof  (snap_proof)
  );

endmodule

// File: tb/tb_er_proof_tracker.sv
// Self-checking bench for er_proof_tracker: a behavioural model checked every cycle plus
// directed literal expectations. Honours ER_PROOF_RUN_COUNT_EN for the counter checks.
module tb_er_proof_tracker;

  localparam int unsigned AW = 16;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc;
  logic          exec_in;
  logic          isr_active;
  logic [AW-1:0] er_lo;
  logic [AW-1:0] er_hi;
  logic          snap_req;
  logic          snap_ack;
  logic          snap_proof;
  logic          proof_valid;
  logic          violation;
  logic [1:0]    run_state;
  logic [CW-1:0] run_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  er_proof_tracker #(
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .exec_in     (exec_in),
    .isr_active  (isr_active),
    .ER_min      (er_lo),
    .ER_max      (er_hi),
    .snap_req    (snap_req),
    .snap_ack    (snap_ack),
    .snap_proof  (snap_proof),
    .proof_valid (proof_valid),
    .violation   (violation),
    .run_state   (run_state),
    .run_count   (run_count)
  );

  // Behavioural model: st 0 idle, 1 running, 2 done, 3 failed.
  typedef struct packed {
    int unsigned st;
    bit          viol;
    bit          pv;
    bit          sack;
    bit          sp;
    bit          req_prev;
    int unsigned cnt;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t c, bit rst, int unsigned p, bit ex, bit isr,
                                        int unsigned lo, int unsigned hi, bit req);
    model_t n = c;
    bit ok = lo <= hi;
    if (rst) begin
      n = '0;
      return n;
    end
    if ((c.st == 1 || c.st == 2) && (!ex || !ok)) begin
      n.st = 3; n.viol = 1'b1;
    end else if (ex && ok && p == lo) begin
      n.st = 1; n.viol = 1'b0;
    end else if (c.st == 1 && p == hi) begin
      n.st = 2;
    end else if (c.st == 1 && (p < lo || p > hi) && !isr) begin
      n.st = 3; n.viol = 1'b1;
    end
    n.pv = (n.st == 2);
`ifdef ER_PROOF_RUN_COUNT_EN
    if (c.st == 1 && n.st == 2 && c.cnt < (2 ** CW) - 1) n.cnt = c.cnt + 1;
`else
    n.cnt = 0;
`endif
    if (!req) begin
      n.sack = 1'b0; n.sp = 1'b0;
    end else if (!c.sack && !c.req_prev) begin
      n.sack = 1'b1; n.sp = c.pv;
    end
    n.req_prev = req;
    return n;
  endfunction

  always @(posedge clk) begin
    m <= model_next(m, reset, pc, exec_in, isr_active, er_lo, er_hi, snap_req);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_run_state", 32'(run_state), m.st);
      chk("m_proof_valid", 32'(proof_valid), 32'(m.pv));
      chk("m_violation", 32'(violation), 32'(m.viol));
      chk("m_snap_ack", 32'(snap_ack), 32'(m.sack));
      chk("m_snap_proof", 32'(snap_proof), 32'(m.sp));
      chk("m_run_count", 32'(run_count), m.cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input int st, input bit pv, input bit vi,
                         input bit sa, input bit sp);
    chk({name, "_state"}, 32'(run_state), st);
    chk({name, "_pv"}, 32'(proof_valid), 32'(pv));
    chk({name, "_viol"}, 32'(violation), 32'(vi));
    chk({name, "_sack"}, 32'(snap_ack), 32'(sa));
    chk({name, "_sproof"}, 32'(snap_proof), 32'(sp));
  endtask

  int run_exp [5];

  initial begin
`ifdef ER_PROOF_RUN_COUNT_EN
    run_exp = '{1, 2, 3, 3, 3};
`else
    run_exp = '{0, 0, 0, 0, 0};
`endif
    reset = 1'b1; pc = '0; exec_in = 1'b1; isr_active = 1'b0;
    er_lo = 16'hE000; er_hi = 16'hE0FE; snap_req = 1'b0;
    tick(); tick();
    cmp_en = 1'b1;
    chk_all("reset", 0, 0, 0, 0, 0);
    chk("reset_count", 32'(run_count), 0);
    reset = 1'b0;
    tick();
    chk_all("idle", 0, 0, 0, 0, 0);

    // Normal run.
    pc = 16'hE000; tick(); chk_all("run_entry", 1, 0, 0, 0, 0);
    pc = 16'hE002; tick(); chk_all("run_mid", 1, 0, 0, 0, 0);
    pc = 16'hE0FE; tick(); chk_all("run_done", 2, 1, 0, 0, 0);
    pc = 16'h1234; tick(); chk_all("done_hold", 2, 1, 0, 0, 0);

    // Upstream abort in DONE, then re-entry clears violation.
    exec_in = 1'b0; tick(); chk_all("abort", 3, 0, 1, 0, 0);
    exec_in = 1'b1; tick(); chk_all("fail_hold", 3, 0, 1, 0, 0);
    pc = 16'hE000; tick(); chk_all("reentry", 1, 0, 0, 0, 0);

    // Escape tolerated under ISR, fatal without.
    pc = 16'hC000; isr_active = 1'b1; tick(); chk_all("isr_escape", 1, 0, 0, 0, 0);
    isr_active = 1'b0; tick(); chk_all("escape", 3, 0, 1, 0, 0);

    // Snapshot freeze across an abort.
    pc = 16'hE000; tick();
    pc = 16'hE0FE; tick(); chk_all("snap_pre", 2, 1, 0, 0, 0);
    snap_req = 1'b1; tick(); chk_all("snap_cap", 2, 1, 0, 1, 1);
    exec_in = 1'b0; tick(); chk_all("snap_abort", 3, 0, 1, 1, 1);
    exec_in = 1'b1; tick(); chk_all("snap_frozen", 3, 0, 1, 1, 1);
    snap_req = 1'b0; tick(); chk_all("snap_rel", 3, 0, 1, 0, 0);

    // Reset mid-run with a held snapshot.
    pc = 16'hE000; tick();
    snap_req = 1'b1; tick(); chk_all("snap_run", 1, 0, 0, 1, 0);
    pc = 16'hE002; reset = 1'b1; tick(); chk_all("mid_reset", 0, 0, 0, 0, 0);
    chk("mid_reset_count", 32'(run_count), 0);
    snap_req = 1'b0; reset = 1'b0;

    // Inverted bounds never enter.
    er_lo = 16'hE100; er_hi = 16'hE000; pc = 16'hE100;
    tick(); chk_all("bad_cfg", 0, 0, 0, 0, 0);
    tick(); chk_all("bad_cfg2", 0, 0, 0, 0, 0);

    // Five complete runs exercise counter saturation and re-entry from DONE.
    er_lo = 16'hE000; er_hi = 16'hE0FE;
    for (int i = 0; i < 5; i++) begin
      pc = 16'hE000; tick(); chk("runs_entry", 32'(run_state), 1);
      pc = 16'hE0FE; tick(); chk("runs_done", 32'(run_state), 2);
      chk($sformatf("run_count_%0d", i), 32'(run_count), run_exp[i]);
    end

    // Recapture after the request has been low for a cycle.
    snap_req = 1'b1; tick(); chk_all("cap1", 2, 1, 0, 1, 1);
    snap_req = 1'b0; tick(); chk_all("cap_gap", 2, 1, 0, 0, 0);
    snap_req = 1'b1; tick(); chk_all("cap2", 2, 1, 0, 1, 1);
    snap_req = 1'b0; tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
